// File: rtl/mem_copy_engine.sv
`timescale 1ns/1ps
// Word-copy initiator on the 68-bit put/get memory protocol: read one word, write it, repeat.
// Define MEM_COPY_CHECKSUM_EN to add the running 32-bit checksum output of all words read.
module mem_copy_engine #(
  parameter int          LEN_WIDTH = 16,
  parameter logic [31:0] MEM_BYTES = 32'h00010000
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 cmd_enable,
  output logic                 cmd_ready,
  input  logic [31:0]          cmd_src,
  input  logic [31:0]          cmd_dst,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  output logic                 mem_put_enable,
  input  logic                 mem_put_ready,
  output logic [67:0]          mem_put_request,
  output logic                 mem_get_enable,
  input  logic                 mem_get_ready,
  input  logic [67:0]          mem_get_response,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [LEN_WIDTH-1:0] words_done
`ifdef MEM_COPY_CHECKSUM_EN
  ,
  output logic [31:0]          checksum
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_REQ = 3'd1,
    RD_RSP = 3'd2,
    WR_REQ = 3'd3,
    WR_RSP = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t               state_r;
  logic [31:0]          rd_addr_r;
  logic [31:0]          wr_addr_r;
  logic [31:0]          buf_r;
  logic [LEN_WIDTH-1:0] len_r;
  logic [LEN_WIDTH-1:0] words_done_r;
  logic                 err_r;
  logic                 busy_r;
  logic                 done_r;

  logic                 put_req_s;
  logic                 get_req_s;
  logic [67:0]          req_s;
  logic [32:0]          len_bytes_s;
  logic [32:0]          src_end_s;
  logic [32:0]          dst_end_s;
  logic                 cmd_bad_s;
  logic [3:0]           rsp_be_s;
  logic [31:0]          rsp_addr_s;
  logic [31:0]          rsp_data_s;
  logic                 rd_ok_s;
  logic                 wr_ok_s;
  logic                 last_s;

  // Request phase decode: the request word is held stable for the whole REQ state.
  always_comb begin
    put_req_s = 1'b0;
    get_req_s = 1'b0;
    req_s     = 68'h0;
    case (state_r)
      RD_REQ: begin
        put_req_s = 1'b1;
        req_s     = {4'b0000, rd_addr_r, 32'h0000_0000};
      end
      RD_RSP: get_req_s = 1'b1;
      WR_REQ: begin
        put_req_s = 1'b1;
        req_s     = {4'b1111, wr_addr_r, buf_r};
      end
      WR_RSP: get_req_s = 1'b1;
      default: begin
        put_req_s = 1'b0;
        get_req_s = 1'b0;
        req_s     = 68'h0;
      end
    endcase
  end

  assign cmd_ready       = RST_N && (state_r == IDLE);
  assign mem_put_enable  = RST_N && put_req_s && mem_put_ready;
  assign mem_put_request = RST_N ? req_s : 68'h0;
  assign mem_get_enable  = RST_N && get_req_s && mem_get_ready;

  // 33-bit end addresses so a range running past 4 GiB cannot wrap into a legal one
  assign len_bytes_s = 33'(cmd_len) << 2;
  assign src_end_s   = {1'b0, cmd_src} + len_bytes_s;
  assign dst_end_s   = {1'b0, cmd_dst} + len_bytes_s;
  assign cmd_bad_s   = (cmd_src[1:0] != 2'b00) || (cmd_dst[1:0] != 2'b00) ||
                       (src_end_s > {1'b0, MEM_BYTES}) || (dst_end_s > {1'b0, MEM_BYTES});

  assign rsp_be_s   = mem_get_response[67:64];
  assign rsp_addr_s = mem_get_response[63:32];
  assign rsp_data_s = mem_get_response[31:0];
  assign rd_ok_s    = (rsp_be_s == 4'b0000) && (rsp_addr_s == rd_addr_r);
  assign wr_ok_s    = (rsp_be_s == 4'b1111) && (rsp_addr_s == wr_addr_r);
  assign last_s     = (words_done_r + LEN_WIDTH'(1)) == len_r;

  // Copy sequencer with registered status outputs
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r      <= IDLE;
      rd_addr_r    <= 32'h0;
      wr_addr_r    <= 32'h0;
      buf_r        <= 32'h0;
      len_r        <= '0;
      words_done_r <= '0;
      err_r        <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_enable) begin
            rd_addr_r    <= cmd_src;
            wr_addr_r    <= cmd_dst;
            len_r        <= cmd_len;
            words_done_r <= '0;
            busy_r       <= 1'b1;
            if (cmd_len == '0) begin
              err_r   <= 1'b0;
              done_r  <= 1'b1;
              state_r <= DONE;
            end else if (cmd_bad_s) begin
              err_r   <= 1'b1;
              done_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              err_r   <= 1'b0;
              state_r <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          if (mem_put_enable) state_r <= RD_RSP;
        end
        RD_RSP: begin
          if (mem_get_enable) begin
            if (!rd_ok_s) begin
              err_r   <= 1'b1;
              done_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              buf_r   <= rsp_data_s;
              state_r <= WR_REQ;
            end
          end
        end
        WR_REQ: begin
          if (mem_put_enable) state_r <= WR_RSP;
        end
        WR_RSP: begin
          if (mem_get_enable) begin
            if (!wr_ok_s) begin
              err_r   <= 1'b1;
              done_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              words_done_r <= words_done_r + LEN_WIDTH'(1);
              rd_addr_r    <= rd_addr_r + 32'd4;
              wr_addr_r    <= wr_addr_r + 32'd4;
              if (last_s) begin
                done_r  <= 1'b1;
                state_r <= DONE;
              end else begin
                state_r <= RD_REQ;
              end
            end
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;
  assign words_done = words_done_r;

`ifdef MEM_COPY_CHECKSUM_EN
  logic [31:0] checksum_r;

  // Sum of every accepted read word of the current command; holds after completion
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      checksum_r <= 32'h0;
    end else if (cmd_ready && cmd_enable) begin
      checksum_r <= 32'h0;
    end else if ((state_r == RD_RSP) && mem_get_enable && rd_ok_s) begin
      checksum_r <= checksum_r + rsp_data_s;
    end else begin
      checksum_r <= checksum_r;
    end
  end

  assign checksum = checksum_r;
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
`timescale 1ns/1ps
// Scoreboard bench for mem_copy_engine: stimulus queues expected puts and completions,
// a monitor branch compares them as the engine presents them; a behavioural memory answers.
module tb_mem_copy_engine;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        cmd_enable = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_src = 32'h0;
  logic [31:0] cmd_dst = 32'h0;
  logic [15:0] cmd_len = 16'h0;
  logic        mem_put_enable;
  logic        mem_put_ready;
  logic [67:0] mem_put_request;
  logic        mem_get_enable;
  logic        mem_get_ready;
  logic [67:0] mem_get_response;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_done;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  mem_copy_engine #(.LEN_WIDTH(16), .MEM_BYTES(32'h00010000)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .cmd_enable(cmd_enable), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .mem_put_enable(mem_put_enable), .mem_put_ready(mem_put_ready),
    .mem_put_request(mem_put_request),
    .mem_get_enable(mem_get_enable), .mem_get_ready(mem_get_ready),
    .mem_get_response(mem_get_response),
    .busy(busy), .done(done), .err(err), .words_done(words_done)
`ifdef MEM_COPY_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural memory: one response register, optional random put stalls and read-address corruption
  logic [31:0] mem [0:16383];
  logic        resp_valid = 1'b0;
  logic [67:0] resp = 68'h0;
  logic        init_mem = 1'b0;
  logic        stall_mode = 1'b0;
  logic        rdy_rand = 1'b1;
  logic        corrupt_en = 1'b0;
  logic [31:0] corrupt_addr = 32'h0;

  assign mem_put_ready    = stall_mode ? rdy_rand : 1'b1;
  assign mem_get_ready    = resp_valid;
  assign mem_get_response = resp;

  always @(posedge CLK) begin
    rdy_rand <= 1'($urandom_range(0, 1));
    if (init_mem)
      for (int k = 0; k < 16384; k++)
        mem[k] <= (k >= 64 && k < 68) ? 32'(k - 63) : 32'h0;
    if (!RST_N) begin
      resp_valid <= 1'b0;
    end else begin
      if (mem_get_enable) resp_valid <= 1'b0;
      if (mem_put_enable) begin
        resp_valid <= 1'b1;
        if (mem_put_request[67:64] == 4'hF) begin
          mem[mem_put_request[47:34]] <= mem_put_request[31:0];
          resp <= mem_put_request;
        end else begin
          resp <= {4'h0,
                   (corrupt_en && mem_put_request[63:32] == corrupt_addr) ?
                     (mem_put_request[63:32] ^ 32'h10) : mem_put_request[63:32],
                   mem[mem_put_request[47:34]]};
        end
      end
    end
  end

  typedef struct {
    logic        err;
    logic [15:0] wd;
    int          cyc;
    logic [31:0] csum;
  } done_t;

  logic [67:0] put_q[$];
  done_t       done_q[$];
  logic [31:0] ref_mem [0:16383];
  int          checks = 0;
  int          errors = 0;
  bit          stim_done = 1'b0;

  task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Queue expectations for one command (reference forward copy), then present it.
  task automatic issue(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                       input bit exp_err, input int n_ok, input bit part_rd,
                       input bit timed, input bit push_done);
    done_t       e;
    logic [31:0] sa, da, w, sum;
    int          lim;
    lim = 0;
    @(posedge CLK); #1;
    while (cmd_ready !== 1'b1 && lim < 1000) begin
      @(posedge CLK); #1;
      lim++;
    end
    chk("cmd_ready_before_issue", cmd_ready, 1'b1);
    sum = 32'h0;
    for (int k = 0; k < n_ok; k++) begin
      sa = s + 32'(4 * k);
      da = d + 32'(4 * k);
      w  = ref_mem[sa[15:2]];
      put_q.push_back({4'h0, sa, 32'h0});
      put_q.push_back({4'hF, da, w});
      ref_mem[da[15:2]] = w;
      sum += w;
    end
    if (part_rd) begin
      sa = s + 32'(4 * n_ok);
      put_q.push_back({4'h0, sa, 32'h0});
    end
    e.err  = exp_err;
    e.wd   = 16'(n_ok);
    e.cyc  = timed ? (cyc + 4 * n_ok + 1 + (part_rd ? 2 : 0)) : -1;
    e.csum = sum;
    if (push_done) done_q.push_back(e);
    cmd_src    = s;
    cmd_dst    = d;
    cmd_len    = n;
    cmd_enable = 1'b1;
    @(posedge CLK); #1;
    cmd_enable = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int lim;
    lim = 0;
    while ((done_q.size() != 0 || put_q.size() != 0 || cmd_ready !== 1'b1) && lim < 2000) begin
      @(posedge CLK); #1;
      lim++;
    end
    chk({nm, "_complete"}, 1'(lim < 2000), 1'b1);
  endtask

  initial begin
    for (int k = 0; k < 16384; k++)
      ref_mem[k] = (k >= 64 && k < 68) ? 32'(k - 63) : 32'h0;
    fork
      begin : monitor
        done_t e;
        while (!stim_done) begin
          @(negedge CLK);
          if (mem_put_enable === 1'b1) begin
            if (put_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_put: got %0h expected no request", mem_put_request);
            end else begin
              chk("put_request", mem_put_request, put_q.pop_front());
            end
          end
          if (done === 1'b1) begin
            if (done_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
              e = done_q.pop_front();
              chk("done_err", err, e.err);
              chk("done_words", words_done, e.wd);
              if (e.cyc >= 0) chk("done_cycle", cyc, e.cyc);
`ifdef MEM_COPY_CHECKSUM_EN
              chk("done_checksum", checksum, e.csum);
`endif
            end
          end
        end
      end
      begin : stimulus
        init_mem = 1'b1;
        @(posedge CLK); #1;
        init_mem = 1'b0;
        @(negedge CLK);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_words_done", words_done, 16'h0);
        chk("rst_put_enable", mem_put_enable, 1'b0);
        chk("rst_get_enable", mem_get_enable, 1'b0);
        chk("rst_put_request", mem_put_request, 68'h0);
`ifdef MEM_COPY_CHECKSUM_EN
        chk("rst_checksum", checksum, 32'h0);
`endif
        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(negedge CLK);
        chk("idle_cmd_ready", cmd_ready, 1'b1);

        // basic 4-word copy; commands issued while busy must be ignored
        issue(32'h100, 32'h200, 16'd4, 1'b0, 4, 1'b0, 1'b1, 1'b1);
        repeat (2) begin @(posedge CLK); #1; end
        chk("busy_cmd_ready", cmd_ready, 1'b0);
        chk("busy_flag", busy, 1'b1);
        cmd_src = 32'h500; cmd_dst = 32'h600; cmd_len = 16'd1; cmd_enable = 1'b1;
        repeat (2) begin @(posedge CLK); #1; end
        cmd_enable = 1'b0;
        wait_done("copy4");
        chk("dst0", mem[32'h200 >> 2], 32'd1);
        chk("dst1", mem[32'h204 >> 2], 32'd2);
        chk("dst2", mem[32'h208 >> 2], 32'd3);
        chk("dst3", mem[32'h20C >> 2], 32'd4);
        chk("idle_words_done", words_done, 16'd4);

        issue(32'h100, 32'h200, 16'd0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
        wait_done("len0");

        issue(32'h102, 32'h200, 16'd1, 1'b1, 0, 1'b0, 1'b1, 1'b1);
        wait_done("misalign");
        chk("err_sticky", err, 1'b1);
        issue(32'h100, 32'h400, 16'd1, 1'b0, 1, 1'b0, 1'b1, 1'b1);
        wait_done("err_clear");
        chk("err_cleared", err, 1'b0);

        issue(32'h100, 32'hFFF8, 16'd4, 1'b1, 0, 1'b0, 1'b1, 1'b1);
        wait_done("bound_reject");
        issue(32'h100, 32'hFFF0, 16'd4, 1'b0, 4, 1'b0, 1'b1, 1'b1);
        wait_done("bound_ok");
        chk("bound_last_word", mem[32'hFFFC >> 2], 32'd4);

        corrupt_en = 1'b1; corrupt_addr = 32'h104;
        issue(32'h100, 32'h600, 16'd4, 1'b1, 1, 1'b1, 1'b1, 1'b1);
        wait_done("corrupt");
        corrupt_en = 1'b0;

        // reset while in WR_REQ of the second word
        issue(32'h100, 32'h300, 16'd4, 1'b0, 1, 1'b1, 1'b0, 1'b0);
        repeat (6) begin @(posedge CLK); #1; end
        RST_N = 1'b0;
        @(negedge CLK);
        chk("midrst_cmd_ready", cmd_ready, 1'b0);
        chk("midrst_put_enable", mem_put_enable, 1'b0);
        chk("midrst_get_enable", mem_get_enable, 1'b0);
        chk("midrst_put_request", mem_put_request, 68'h0);
        @(posedge CLK); #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_err", err, 1'b0);
        chk("midrst_words_done", words_done, 16'h0);
        RST_N = 1'b1;
        issue(32'h100, 32'h300, 16'd4, 1'b0, 4, 1'b0, 1'b1, 1'b1);
        wait_done("rerun");

        stall_mode = 1'b1;
        issue(32'h100, 32'h500, 16'd3, 1'b0, 3, 1'b0, 1'b0, 1'b1);
        wait_done("stall");
        stall_mode = 1'b0;
        chk("stall_dst2", mem[32'h508 >> 2], 32'd3);

        // overlapping forward copy smears the first word upward
        issue(32'h100, 32'h104, 16'd3, 1'b0, 3, 1'b0, 1'b1, 1'b1);
        wait_done("overlap");
        chk("overlap_top", mem[32'h10C >> 2], 32'd1);

        repeat (3) @(posedge CLK);
        stim_done = 1'b1;
      end
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
